// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NUM_REQ requesters.
// Optional watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil_master_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_REQ-1:0]               req_v_i,
  input  logic [NUM_REQ-1:0]               req_w_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic [NUM_REQ-1:0]               resp_v_o,
  output logic [DATA_WIDTH-1:0]            resp_data_o,
  output logic [1:0]                       resp_err_o,
  input  logic [NUM_REQ-1:0]               resp_ready_i,
  output logic [ADDR_WIDTH-1:0]            m01_axi_awaddr,
  output logic [2:0]                       m01_axi_awprot,
  output logic                             m01_axi_awvalid,
  input  logic                             m01_axi_awready,
  output logic [DATA_WIDTH-1:0]            m01_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]          m01_axi_wstrb,
  output logic                             m01_axi_wvalid,
  input  logic                             m01_axi_wready,
  input  logic [1:0]                       m01_axi_bresp,
  input  logic                             m01_axi_bvalid,
  output logic                             m01_axi_bready,
  output logic [ADDR_WIDTH-1:0]            m01_axi_araddr,
  output logic [2:0]                       m01_axi_arprot,
  output logic                             m01_axi_arvalid,
  input  logic                             m01_axi_arready,
  input  logic [DATA_WIDTH-1:0]            m01_axi_rdata,
  input  logic [1:0]                       m01_axi_rresp,
  input  logic                             m01_axi_rvalid,
  output logic                             m01_axi_rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StWaddr, StWresp, StRaddr, StRdata, StResp} state_e;

  state_e                r_state, w_state_nxt;
  logic [PW-1:0]         r_rr, r_gnt, w_gnt_idx, w_rr_nxt;
  logic                  w_found, w_timeout;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [StrbW-1:0]      r_wstrb;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                  w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt, w_arvalid_nxt, w_rready_nxt;
  logic [NUM_REQ-1:0]    r_resp_v, w_resp_v_nxt;
  logic [DATA_WIDTH-1:0] r_resp_data, w_resp_data_nxt;
  logic [1:0]            r_resp_err, w_resp_err_nxt;

`ifdef AXIL_ARB_TIMEOUT_EN
  // Late b/r beats after a timeout are sunk while idle.
  localparam logic IdleBeatSink = 1'b1;
  logic        w_wait;
  logic [15:0] r_tmo_cnt;

  assign w_wait = (r_state == StWaddr) || (r_state == StWresp) ||
                  (r_state == StRaddr) || (r_state == StRdata);
  assign w_timeout = w_wait && (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tmo_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmo_cnt <= '0;
    end else if (w_wait) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  localparam logic IdleBeatSink = 1'b0;
  assign w_timeout = 1'b0;
`endif

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int k;
    k         = 0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      k = int'(r_rr) + i;
      if (k >= int'(NUM_REQ)) k = k - int'(NUM_REQ);
      if (!w_found && req_v_i[k]) begin
        w_found   = 1'b1;
        w_gnt_idx = PW'(k);
      end
    end
    w_rr_nxt = (w_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_found) w_state_nxt = req_w_i[w_gnt_idx] ? StWaddr : StRaddr;
      StWaddr: begin
        if ((!r_awvalid || m01_axi_awready) && (!r_wvalid || m01_axi_wready)) begin
          w_state_nxt = StWresp;
        end else if (w_timeout) begin
          w_state_nxt = StResp;
        end
      end
      StWresp: if (m01_axi_bvalid || w_timeout) w_state_nxt = StResp;
      StRaddr: begin
        if (m01_axi_arready) w_state_nxt = StRdata;
        else if (w_timeout)  w_state_nxt = StResp;
      end
      StRdata: if (m01_axi_rvalid || w_timeout) w_state_nxt = StResp;
      StResp:  if (resp_ready_i[r_gnt]) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Next values of the registered outputs, plus the combinational grant strobe.
  always_comb begin
    req_ready_o = '0;
    if (r_state == StIdle && w_found) req_ready_o[w_gnt_idx] = 1'b1;

    if (r_state == StIdle) begin
      w_awvalid_nxt = (w_state_nxt == StWaddr);
      w_wvalid_nxt  = (w_state_nxt == StWaddr);
    end else begin
      w_awvalid_nxt = (w_state_nxt == StWaddr) && r_awvalid && !m01_axi_awready;
      w_wvalid_nxt  = (w_state_nxt == StWaddr) && r_wvalid && !m01_axi_wready;
    end
    w_arvalid_nxt = (w_state_nxt == StRaddr);
    w_bready_nxt  = (w_state_nxt == StWresp) || (IdleBeatSink && w_state_nxt == StIdle);
    w_rready_nxt  = (w_state_nxt == StRdata) || (IdleBeatSink && w_state_nxt == StIdle);

    w_resp_v_nxt = '0;
    if (w_state_nxt == StResp) w_resp_v_nxt[r_gnt] = 1'b1;

    w_resp_data_nxt = r_resp_data;
    w_resp_err_nxt  = r_resp_err;
    if (r_state == StWresp && m01_axi_bvalid) begin
      w_resp_data_nxt = '0;
      w_resp_err_nxt  = m01_axi_bresp;
    end else if (r_state == StRdata && m01_axi_rvalid) begin
      w_resp_data_nxt = m01_axi_rdata;
      w_resp_err_nxt  = m01_axi_rresp;
    end else if (w_timeout && w_state_nxt == StResp) begin
      w_resp_data_nxt = '0;
      w_resp_err_nxt  = 2'b10;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rr        <= '0;
      r_gnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_resp_v    <= '0;
      r_resp_data <= '0;
      r_resp_err  <= '0;
    end else begin
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_resp_v    <= w_resp_v_nxt;
      r_resp_data <= w_resp_data_nxt;
      r_resp_err  <= w_resp_err_nxt;
      if (r_state == StIdle && w_found) begin
        r_gnt   <= w_gnt_idx;
        r_rr    <= w_rr_nxt;
        r_addr  <= req_addr_i[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata <= req_data_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        r_wstrb <= req_wstrb_i[w_gnt_idx*StrbW +: StrbW];
      end
    end
  end

  assign m01_axi_awaddr  = r_addr;
  assign m01_axi_araddr  = r_addr;
  assign m01_axi_awprot  = 3'b000;
  assign m01_axi_arprot  = 3'b000;
  assign m01_axi_awvalid = r_awvalid;
  assign m01_axi_wdata   = r_wdata;
  assign m01_axi_wstrb   = r_wstrb;
  assign m01_axi_wvalid  = r_wvalid;
  assign m01_axi_bready  = r_bready;
  assign m01_axi_arvalid = r_arvalid;
  assign m01_axi_rready  = r_rready;
  assign resp_v_o        = r_resp_v;
  assign resp_data_o     = r_resp_data;
  assign resp_err_o      = r_resp_err;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with three requesters; the slave side is
// driven step by step from the main initial block.
module tb_axil_master_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [2:0]  req_v_i, req_w_i, req_ready_o, resp_v_o, resp_ready_i;
  logic [95:0] req_addr_i, req_data_i;
  logic [11:0] req_wstrb_i;
  logic [31:0] resp_data_o;
  logic [1:0]  resp_err_o;
  logic [31:0] m01_axi_awaddr, m01_axi_wdata, m01_axi_araddr, m01_axi_rdata;
  logic [2:0]  m01_axi_awprot, m01_axi_arprot;
  logic [3:0]  m01_axi_wstrb;
  logic [1:0]  m01_axi_bresp, m01_axi_rresp;
  logic        m01_axi_awvalid, m01_axi_awready, m01_axi_wvalid, m01_axi_wready;
  logic        m01_axi_bvalid, m01_axi_bready, m01_axi_arvalid, m01_axi_arready;
  logic        m01_axi_rvalid, m01_axi_rready;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam logic IdleRdy = 1'b1;
`else
  localparam logic IdleRdy = 1'b0;
`endif

  int   n_pass = 0, n_chk = 0;
  int   n_aw = 0, n_w = 0, n_ar = 0, n_ovl = 0;
  int   b_aw, b_w, b_ar, n_arv;
  logic got;

  axil_master_arbiter #(
    .NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_v_i(req_v_i), .req_w_i(req_w_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_wstrb_i(req_wstrb_i), .req_ready_o(req_ready_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .resp_ready_i(resp_ready_i),
    .m01_axi_awaddr(m01_axi_awaddr), .m01_axi_awprot(m01_axi_awprot),
    .m01_axi_awvalid(m01_axi_awvalid), .m01_axi_awready(m01_axi_awready),
    .m01_axi_wdata(m01_axi_wdata), .m01_axi_wstrb(m01_axi_wstrb),
    .m01_axi_wvalid(m01_axi_wvalid), .m01_axi_wready(m01_axi_wready),
    .m01_axi_bresp(m01_axi_bresp), .m01_axi_bvalid(m01_axi_bvalid),
    .m01_axi_bready(m01_axi_bready),
    .m01_axi_araddr(m01_axi_araddr), .m01_axi_arprot(m01_axi_arprot),
    .m01_axi_arvalid(m01_axi_arvalid), .m01_axi_arready(m01_axi_arready),
    .m01_axi_rdata(m01_axi_rdata), .m01_axi_rresp(m01_axi_rresp),
    .m01_axi_rvalid(m01_axi_rvalid), .m01_axi_rready(m01_axi_rready)
  );

  always #5 aclk = ~aclk;

  // Handshake counters and a one-outstanding monitor.
  always @(posedge aclk) begin
    if (m01_axi_awvalid && m01_axi_awready) n_aw <= n_aw + 1;
    if (m01_axi_wvalid && m01_axi_wready)   n_w  <= n_w + 1;
    if (m01_axi_arvalid && m01_axi_arready) n_ar <= n_ar + 1;
    if ((m01_axi_arvalid && m01_axi_rready) || ($countones(resp_v_o) > 1) ||
        ((m01_axi_awvalid || m01_axi_wvalid) && (m01_axi_arvalid || m01_axi_rready)))
      n_ovl <= n_ovl + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Zero-wait read: accept, AR beat, R beat, response; resp_v lands 3 cycles after accept.
  task automatic rd_txn(input string tag, input int r, input logic [2:0] vmask,
                        input logic [31:0] addr, input logic [31:0] rdat, input logic [1:0] rsp);
    @(negedge aclk);
    req_v_i = vmask; req_w_i = 3'b000; req_addr_i[r*32 +: 32] = addr;
    #1 chk({tag, "_ready"}, req_ready_o, 64'(1 << r));
    @(negedge aclk);
    req_v_i = 3'b000; m01_axi_arready = 1'b1;
    #1 chk({tag, "_arvalid"}, m01_axi_arvalid, 1);
    chk({tag, "_araddr"}, m01_axi_araddr, addr);
    chk({tag, "_ready_drop"}, req_ready_o, 0);
    @(negedge aclk);
    m01_axi_arready = 1'b0; m01_axi_rvalid = 1'b1; m01_axi_rdata = rdat; m01_axi_rresp = rsp;
    #1 chk({tag, "_arvalid_1cyc"}, m01_axi_arvalid, 0);
    chk({tag, "_rready"}, m01_axi_rready, 1);
    @(negedge aclk);
    m01_axi_rvalid = 1'b0; resp_ready_i = 3'(1 << r);
    #1 chk({tag, "_resp_v"}, resp_v_o, 64'(1 << r));
    chk({tag, "_rdata"}, resp_data_o, rdat);
    chk({tag, "_err"}, resp_err_o, rsp);
    @(negedge aclk);
    resp_ready_i = 3'b000;
    #1 chk({tag, "_resp_v_clr"}, resp_v_o, 0);
    chk({tag, "_rready_idle"}, m01_axi_rready, IdleRdy);
  endtask

  initial begin
    aresetn = 1'b0;
    req_v_i = '0; req_w_i = '0; req_addr_i = '0; req_data_i = '0; req_wstrb_i = '0;
    resp_ready_i = '0;
    m01_axi_awready = 0; m01_axi_wready = 0; m01_axi_bvalid = 0; m01_axi_bresp = '0;
    m01_axi_arready = 0; m01_axi_rvalid = 0; m01_axi_rdata = '0; m01_axi_rresp = '0;

    // Reset state
    @(negedge aclk); #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_valids", {m01_axi_awvalid, m01_axi_wvalid, m01_axi_arvalid}, 0);
    chk("rst_readies", {m01_axi_bready, m01_axi_rready}, 0);
    chk("rst_data", resp_data_o, 0);
    chk("rst_err", resp_err_o, 0);
    @(negedge aclk); aresetn = 1'b1;

    // 1: single read from req0
    rd_txn("t1", 0, 3'b001, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00);

    // 2: write from req1, slave takes W two cycles before AW
    b_aw = n_aw; b_w = n_w;
    @(negedge aclk);
    req_v_i = 3'b010; req_w_i = 3'b010; req_addr_i[32 +: 32] = 32'h0000_0200;
    req_data_i[32 +: 32] = 32'h1234_5678; req_wstrb_i[4 +: 4] = 4'hF;
    #1 chk("t2_ready", req_ready_o, 3'b010);
    @(negedge aclk);
    req_v_i = 3'b000; req_w_i = 3'b000; m01_axi_wready = 1'b1;
    #1 chk("t2_both_valid", {m01_axi_awvalid, m01_axi_wvalid}, 2'b11);
    chk("t2_wdata", m01_axi_wdata, 32'h1234_5678);
    chk("t2_wstrb", m01_axi_wstrb, 4'hF);
    chk("t2_awaddr", m01_axi_awaddr, 32'h0000_0200);
    @(negedge aclk);
    m01_axi_wready = 1'b0;
    #1 chk("t2_w_dropped", {m01_axi_awvalid, m01_axi_wvalid}, 2'b10);
    @(negedge aclk);
    m01_axi_awready = 1'b1;
    #1 chk("t2_aw_held", {m01_axi_awvalid, m01_axi_wvalid}, 2'b10);
    @(negedge aclk);
    m01_axi_awready = 1'b0; m01_axi_bvalid = 1'b1; m01_axi_bresp = 2'b00;
    #1 chk("t2_wresp", {m01_axi_awvalid, m01_axi_wvalid, m01_axi_bready}, 3'b001);
    @(negedge aclk);
    m01_axi_bvalid = 1'b0; resp_ready_i = 3'b010;
    #1 chk("t2_resp_v", resp_v_o, 3'b010);
    chk("t2_err", resp_err_o, 2'b00);
    chk("t2_data_zero", resp_data_o, 0);
    chk("t2_one_aw", n_aw - b_aw, 1);
    chk("t2_one_w", n_w - b_w, 1);
    @(negedge aclk); resp_ready_i = 3'b000;

    // 4: SLVERR read goes only to req2
    rd_txn("t4", 2, 3'b100, 32'h0000_0300, 32'hCAFE_F00D, 2'b10);

    // 3: all three requesting continuously
    b_ar = n_ar;
    @(negedge aclk);
    req_v_i = 3'b111; req_w_i = 3'b000;
    m01_axi_arready = 1'b1; m01_axi_rvalid = 1'b1; m01_axi_rdata = 32'h33; m01_axi_rresp = 2'b00;
    resp_ready_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        #1 got = (req_ready_o != 3'b000);
        if (!got) @(negedge aclk);
      end
      chk($sformatf("t3_grant%0d", k), req_ready_o, 64'(1 << (k % 3)));
      @(negedge aclk);
    end
    req_v_i = 3'b000;
    repeat (3) @(negedge aclk);
    m01_axi_arready = 1'b0; m01_axi_rvalid = 1'b0; resp_ready_i = 3'b000;
    #1 chk("t3_ar_count", n_ar - b_ar, 6);
    chk("t3_idle", resp_v_o, 0);

    // Write with AW and W accepted in the same cycle, DECERR response
    @(negedge aclk);
    req_v_i = 3'b100; req_w_i = 3'b100; req_addr_i[64 +: 32] = 32'h0000_0700;
    req_data_i[64 +: 32] = 32'hA5A5_0001; req_wstrb_i[8 +: 4] = 4'h3;
    #1 chk("t7_ready", req_ready_o, 3'b100);
    @(negedge aclk);
    req_v_i = 3'b000; req_w_i = 3'b000; m01_axi_awready = 1'b1; m01_axi_wready = 1'b1;
    #1 chk("t7_wstrb", m01_axi_wstrb, 4'h3);
    @(negedge aclk);
    m01_axi_awready = 1'b0; m01_axi_wready = 1'b0; m01_axi_bvalid = 1'b1; m01_axi_bresp = 2'b11;
    #1 chk("t7_wresp", {m01_axi_awvalid, m01_axi_wvalid, m01_axi_bready}, 3'b001);
    @(negedge aclk);
    m01_axi_bvalid = 1'b0; resp_ready_i = 3'b100;
    #1 chk("t7_resp", {resp_v_o, resp_err_o}, {3'b100, 2'b11});
    chk("t7_data_zero", resp_data_o, 0);
    @(negedge aclk); resp_ready_i = 3'b000;

    // 5: reset asserted during RDATA
    @(negedge aclk);
    req_v_i = 3'b010; req_w_i = 3'b000; req_addr_i[32 +: 32] = 32'h0000_0400;
    #1 chk("t5_ready", req_ready_o, 3'b010);
    @(negedge aclk);
    req_v_i = 3'b000; m01_axi_arready = 1'b1;
    @(negedge aclk);
    m01_axi_arready = 1'b0;
    #1 chk("t5_in_rdata", m01_axi_rready, 1);
    aresetn = 1'b0;
    #1 chk("t5_valids_drop", {m01_axi_awvalid, m01_axi_wvalid, m01_axi_arvalid}, 0);
    chk("t5_readies_drop", {m01_axi_bready, m01_axi_rready}, 0);
    chk("t5_no_resp", resp_v_o, 0);
    @(negedge aclk); aresetn = 1'b1;
    rd_txn("t5b", 0, 3'b011, 32'h0000_0500, 32'h5555_AAAA, 2'b00);

`ifdef AXIL_ARB_TIMEOUT_EN
    // 6: slave never accepts AR; watchdog fires after 16 cycles
    @(negedge aclk);
    req_v_i = 3'b001; req_w_i = 3'b000; req_addr_i[0 +: 32] = 32'h0000_0600;
    #1 chk("t6_ready", req_ready_o, 3'b001);
    @(negedge aclk);
    req_v_i = 3'b000; n_arv = 0; got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      #1 got = (resp_v_o != 3'b000);
      if (!got) begin
        if (m01_axi_arvalid) n_arv++;
        @(negedge aclk);
      end
    end
    chk("t6_ar_cycles", n_arv, 16);
    chk("t6_resp", {resp_v_o, resp_err_o}, {3'b001, 2'b10});
    chk("t6_data_zero", resp_data_o, 0);
    chk("t6_ar_dropped", m01_axi_arvalid, 0);
    resp_ready_i = 3'b001;
    @(negedge aclk); resp_ready_i = 3'b000;
    rd_txn("t6b", 1, 3'b010, 32'h0000_0680, 32'h0BAD_F00D, 2'b00);
`endif

    chk("one_outstanding", n_ovl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
